adc_input_parallel: RTL and testbench
=====================================

ADC_INPUT_PARALLEL -- requirements
Module: adc_input_parallel

Interface
REQ-001 SHALL have parameter DW_ADC, default 10, ADC sample width in bits.
REQ-002 SHALL have parameter DW_BUS, default 16, AXI-Stream tdata width, multiple of 8, DW_BUS >= DW_ADC.
REQ-003 SHALL have parameter FILL, default "LSB", sample alignment in tdata ("LSB" or "MSB").
REQ-004 SHALL have parameter ADC_IQ, default 1, 1 = dual-channel I/Q alternation, 0 = single channel.
REQ-005 SHALL use one clock, aclk; reset is aresetn, asynchronous, active-low.
REQ-006 aclk  in  1  system and sampling clock.
REQ-007 aresetn  in  1  asynchronous active-low reset.
REQ-008 adc_clk_in  in  1  ADC conversion clock reference, same source and phase as aclk; never clocks a flop.
REQ-009 ce  in  1  capture enable.
REQ-010 adc_clk  out  1  ADC clock, equal to adc_clk_in AND ce (combinational).
REQ-011 adc_channel_sel  out  1  ADC channel select, 1 = I, 0 = Q.
REQ-012 adc_data  in  DW_ADC  parallel ADC output bus.
REQ-013 tdata_m_out  out  DW_BUS  sample data.
REQ-014 tstrb_m_out  out  DW_BUS/8  byte strobes.
REQ-015 tid_m_out  out  1  channel tag, 0 = I, 1 = Q; constant 0 when ADC_IQ=0.
REQ-016 tvalid_m_out  out  1  AXI-Stream valid.
REQ-017 tready_m_in  in  1  AXI-Stream ready.

Function
REQ-018 Each aclk rising edge with ce=1 SHALL capture adc_data into a sample register, one capture per cycle.
REQ-019 With ADC_IQ=1, adc_channel_sel SHALL toggle on every capture cycle; with ADC_IQ=0 it SHALL be held 1.
REQ-020 A captured sample SHALL be tagged with the adc_channel_sel value driven in the preceding cycle: 1 gives tid 0, 0 gives tid 1.
REQ-021 FILL="LSB": tdata[DW_ADC-1:0] holds the sample and the upper bits are 0; FILL="MSB": tdata[DW_BUS-1:DW_BUS-DW_ADC] holds the sample and the lower bits are 0; no sign extension, raw code.
REQ-022 tstrb_m_out SHALL be all ones whenever tvalid_m_out=1.
REQ-023 Captured samples SHALL pass through a 4-entry FIFO; the FIFO head drives tdata/tid/tvalid.
REQ-024 Latency: a sample captured at edge N SHALL appear with tvalid=1 after edge N+1 when the FIFO was empty.
REQ-025 tvalid, once asserted, SHALL stay high with tdata/tid/tstrb stable until tready=1 at a rising edge.
REQ-026 Transfer occurs on the edge where tvalid=1 and tready=1; the FIFO then pops.
REQ-027 Simultaneous push and pop SHALL both take effect, and occupancy is unchanged.
REQ-028 When the FIFO is full and no pop occurs, the new sample SHALL be dropped and adc_channel_sel SHALL still toggle.
REQ-029 ce=0: no capture, adc_channel_sel holds, and pending FIFO data still drains.

Reset
REQ-030 While aresetn=0: tvalid_m_out=0, tdata_m_out=0, tid_m_out=0, tstrb_m_out=0, adc_channel_sel=1, FIFO empty.
REQ-031 Reset asserted mid-operation SHALL discard all pending samples immediately (asynchronously).
REQ-032 The first capture SHALL occur on the first aclk rising edge after aresetn deasserts with ce=1.

Structure
REQ-033 A shared package SHALL hold the FILL encodings, the channel tag constants (I=0, Q=1) and the FIFO depth constant (4).
REQ-034 The FIFO SHALL be a sub-module named adc_sample_fifo (width DW_ADC+1, depth 4).

Verification
REQ-035 Reset, then 10-bit ramp 0,1,2… with tready=1 -> tdata 0x0000,0x0001,… with tid alternating 0,1,0,…; tstrb=2'b11.
REQ-036 FILL="MSB", adc_data=10'h3FF -> tdata=16'hFFC0.
REQ-037 tready=0 for 8 cycles -> first 4 samples held, tvalid stays high, tdata stable, next 4 dropped; tready=1 -> exactly 4 transfers in order.
REQ-038 ce=0 for 5 cycles -> adc_clk=0, no new transfers, adc_channel_sel frozen; ce=1 -> alternation resumes.
REQ-039 aresetn pulsed low with 3 samples queued -> tvalid=0 in the same cycle, with no stale data after release.
REQ-040 ADC_IQ=0 -> tid always 0, adc_channel_sel constantly 1.

Source files
------------

// File: rtl/adc_input_parallel_pkg.sv
// Shared constants for the parallel ADC capture path: alignment encodings,
// channel tags and sample FIFO depth.
package adc_input_parallel_pkg;

    localparam logic [23:0] FILL_LSB   = "LSB";
    localparam logic [23:0] FILL_MSB   = "MSB";
    localparam logic        TID_I      = 1'b0;
    localparam logic        TID_Q      = 1'b1;
    localparam int          FIFO_DEPTH = 4;

    // The ADC select line is high for I, the stream tag is low for I.
    function automatic logic sel_to_tid(input logic sel);
        if (sel) begin
            return TID_I;
        end else begin
            return TID_Q;
        end
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Small synchronous FIFO holding tagged ADC samples; a push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module adc_sample_fifo
    import adc_input_parallel_pkg::*;
#(
    parameter int W     = 11,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty   = (cnt_q == {CW{1'b0}});
    assign full    = (cnt_q == CW'(DEPTH));
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_input_parallel.sv
// Parallel ADC capture front end: samples the ADC bus each enabled cycle,
// tags I/Q, buffers through a small FIFO and presents an AXI-Stream master.
module adc_input_parallel
    import adc_input_parallel_pkg::*;
#(
    parameter int          DW_ADC = 10,
    parameter int          DW_BUS = 16,
    parameter logic [23:0] FILL   = "LSB",
    parameter int          ADC_IQ = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  adc_clk_in,
    input  logic                  ce,
    output logic                  adc_clk,
    output logic                  adc_channel_sel,
    input  logic [DW_ADC-1:0]     adc_data,
    output logic [DW_BUS-1:0]     tdata_m_out,
    output logic [DW_BUS/8-1:0]   tstrb_m_out,
    output logic                  tid_m_out,
    output logic                  tvalid_m_out,
    input  logic                  tready_m_in
);

    localparam logic IQ_EN = (ADC_IQ != 0);

    logic              chan_sel_q, chan_sel_d;
    logic [DW_ADC-1:0] smp_q, smp_d;
    logic              smp_tid_q, smp_tid_d;
    logic              smp_vld_q, smp_vld_d;

    logic [DW_ADC:0]   head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              pop_s;
    logic [DW_BUS-1:0] data_ext_s;
    logic [DW_BUS-1:0] data_aligned_s;

    assign adc_clk         = adc_clk_in & ce;
    assign adc_channel_sel = chan_sel_q;

    // Capture stage: the tag reflects the select line driven during the
    // conversion that produced this sample, i.e. before this edge's toggle.
    always_comb begin
        smp_vld_d = ce;
        if (ce) begin
            smp_d      = adc_data;
            smp_tid_d  = sel_to_tid(chan_sel_q);
            chan_sel_d = IQ_EN ? ~chan_sel_q : chan_sel_q;
        end else begin
            smp_d      = smp_q;
            smp_tid_d  = smp_tid_q;
            chan_sel_d = chan_sel_q;
        end
    end

    // Capture stage and channel select registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chan_sel_q <= 1'b1;
            smp_q      <= {DW_ADC{1'b0}};
            smp_tid_q  <= 1'b0;
            smp_vld_q  <= 1'b0;
        end else begin
            chan_sel_q <= chan_sel_d;
            smp_q      <= smp_d;
            smp_tid_q  <= smp_tid_d;
            smp_vld_q  <= smp_vld_d;
        end
    end

    assign pop_s = tvalid_m_out & tready_m_in;

    adc_sample_fifo #(
        .W     (DW_ADC + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .push    (smp_vld_q),
        .wdata   ({smp_tid_q, smp_q}),
        .pop     (pop_s),
        .rd_data (head_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    // Stream outputs are forced to zero whenever no sample is offered.
    always_comb begin
        data_ext_s   = DW_BUS'(head_s[DW_ADC-1:0]);
        tvalid_m_out = ~fifo_empty_s;
        if (FILL == FILL_MSB) begin
            data_aligned_s = data_ext_s << (DW_BUS - DW_ADC);
        end else begin
            data_aligned_s = data_ext_s;
        end
        if (tvalid_m_out) begin
            tdata_m_out = data_aligned_s;
            tstrb_m_out = {(DW_BUS/8){1'b1}};
            tid_m_out   = head_s[DW_ADC];
        end else begin
            tdata_m_out = {DW_BUS{1'b0}};
            tstrb_m_out = {(DW_BUS/8){1'b0}};
            tid_m_out   = 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_input_parallel.sv
// Directed bench for adc_input_parallel: default LSB/IQ instance plus an
// MSB-aligned instance and a single-channel instance sharing the same inputs.
module tb_adc_input_parallel;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        adc_clk_in;
    logic        ce;
    logic [9:0]  adc_data;
    logic        tready;

    logic        d_adc_clk, d_sel, d_tid, d_tvalid;
    logic [15:0] d_tdata;
    logic [1:0]  d_tstrb;
    logic        m_adc_clk, m_sel, m_tid, m_tvalid;
    logic [15:0] m_tdata;
    logic [1:0]  m_tstrb;
    logic        s_adc_clk, s_sel, s_tid, s_tvalid;
    logic [15:0] s_tdata;
    logic [1:0]  s_tstrb;

    int n_total = 0;
    int n_bad   = 0;

    always #5 aclk = ~aclk;
    assign adc_clk_in = aclk;

    adc_input_parallel u_dut (
        .aclk(aclk), .aresetn(aresetn), .adc_clk_in(adc_clk_in), .ce(ce),
        .adc_clk(d_adc_clk), .adc_channel_sel(d_sel), .adc_data(adc_data),
        .tdata_m_out(d_tdata), .tstrb_m_out(d_tstrb), .tid_m_out(d_tid),
        .tvalid_m_out(d_tvalid), .tready_m_in(tready)
    );

    adc_input_parallel #(.FILL("MSB")) u_msb (
        .aclk(aclk), .aresetn(aresetn), .adc_clk_in(adc_clk_in), .ce(ce),
        .adc_clk(m_adc_clk), .adc_channel_sel(m_sel), .adc_data(adc_data),
        .tdata_m_out(m_tdata), .tstrb_m_out(m_tstrb), .tid_m_out(m_tid),
        .tvalid_m_out(m_tvalid), .tready_m_in(tready)
    );

    adc_input_parallel #(.ADC_IQ(0)) u_siq (
        .aclk(aclk), .aresetn(aresetn), .adc_clk_in(adc_clk_in), .ce(ce),
        .adc_clk(s_adc_clk), .adc_channel_sel(s_sel), .adc_data(adc_data),
        .tdata_m_out(s_tdata), .tstrb_m_out(s_tstrb), .tid_m_out(s_tid),
        .tvalid_m_out(s_tvalid), .tready_m_in(tready)
    );

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn  = 1'b0;
        ce       = 1'b0;
        tready   = 1'b0;
        adc_data = 10'd0;
        repeat (3) step();
        check_value("rst_tvalid", 32'(d_tvalid), 32'd0);
        check_value("rst_tdata",  32'(d_tdata),  32'd0);
        check_value("rst_tid",    32'(d_tid),    32'd0);
        check_value("rst_tstrb",  32'(d_tstrb),  32'd0);
        check_value("rst_sel",    32'(d_sel),    32'd1);

        // Ramp with tready high
        aresetn = 1'b1;
        ce      = 1'b1;
        tready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            adc_data = 10'(i);
            step();
            check_value("ramp_adc_clk", 32'(d_adc_clk), 32'd1);
            check_value("ramp_sel", 32'(d_sel), 32'(i % 2));
            check_value("siq_sel",  32'(s_sel), 32'd1);
            if (i == 0) begin
                check_value("ramp_first_tvalid", 32'(d_tvalid), 32'd0);
            end else begin
                check_value("ramp_tvalid", 32'(d_tvalid), 32'd1);
                check_value("ramp_tdata",  32'(d_tdata),  32'(i - 1));
                check_value("ramp_tid",    32'(d_tid),    32'((i - 1) % 2));
                check_value("ramp_tstrb",  32'(d_tstrb),  32'd3);
                check_value("siq_tdata",   32'(s_tdata),  32'(i - 1));
                check_value("siq_tid",     32'(s_tid),    32'd0);
            end
        end

        // ce low: last pending sample drains, then nothing
        ce = 1'b0;
        step();
        check_value("ceoff_adc_clk", 32'(d_adc_clk), 32'd0);
        check_value("ceoff_tdata",   32'(d_tdata),   32'd7);
        check_value("ceoff_tid",     32'(d_tid),     32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check_value("ceoff_tvalid",  32'(d_tvalid),  32'd0);
            check_value("ceoff_sel",     32'(d_sel),     32'd1);
            check_value("ceoff_adc_clk", 32'(d_adc_clk), 32'd0);
        end
        ce = 1'b1;
        adc_data = 10'd8;
        step();
        check_value("resume_sel0", 32'(d_sel), 32'd0);
        adc_data = 10'd9;
        step();
        check_value("resume_tdata", 32'(d_tdata), 32'd8);
        check_value("resume_tid",   32'(d_tid),   32'd0);
        check_value("resume_sel1",  32'(d_sel),   32'd1);
        ce = 1'b0;
        step();
        check_value("drain_tdata", 32'(d_tdata), 32'd9);
        step();
        check_value("drain_empty", 32'(d_tvalid), 32'd0);

        // Backpressure: 8 captures with tready low, plus one flush edge
        tready = 1'b0;
        for (int j = 0; j < 9; j++) begin
            ce       = (j < 8);
            adc_data = 10'(16 + j);
            step();
            if (j == 0) begin
                check_value("bp_first_tvalid", 32'(d_tvalid), 32'd0);
            end else begin
                check_value("bp_tvalid", 32'(d_tvalid), 32'd1);
                check_value("bp_tdata",  32'(d_tdata),  32'h10);
                check_value("bp_tid",    32'(d_tid),    32'd0);
            end
            if (j < 8) begin
                check_value("bp_sel", 32'(d_sel), 32'(j % 2));
            end
        end
        tready = 1'b1;
        ce     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 3) begin
                check_value("bp_out_tdata", 32'(d_tdata), 32'(17 + k));
                check_value("bp_out_tid",   32'(d_tid),   32'((k + 1) % 2));
            end else begin
                check_value("bp_out_done", 32'(d_tvalid), 32'd0);
            end
        end

        // Asynchronous reset with three samples queued
        tready = 1'b0;
        ce     = 1'b1;
        for (int j = 0; j < 3; j++) begin
            adc_data = 10'(32 + j);
            step();
        end
        ce = 1'b0;
        step();
        check_value("q3_tdata", 32'(d_tdata), 32'd32);
        #2;
        aresetn = 1'b0;
        #1;
        check_value("arst_tvalid", 32'(d_tvalid), 32'd0);
        check_value("arst_tdata",  32'(d_tdata),  32'd0);
        check_value("arst_sel",    32'(d_sel),    32'd1);
        step();
        aresetn = 1'b1;
        tready  = 1'b1;
        step();
        step();
        check_value("post_rst_tvalid", 32'(d_tvalid), 32'd0);
        ce = 1'b1;
        adc_data = 10'd40;
        step();
        adc_data = 10'h3FF;
        step();
        check_value("post_rst_tdata", 32'(d_tdata), 32'd40);
        check_value("post_rst_tid",   32'(d_tid),   32'd0);
        ce = 1'b0;
        step();
        check_value("lsb_full_tdata", 32'(d_tdata), 32'h03FF);
        check_value("lsb_full_tid",   32'(d_tid),   32'd1);
        check_value("msb_tdata",      32'(m_tdata), 32'hFFC0);
        check_value("msb_tstrb",      32'(m_tstrb), 32'd3);
        check_value("siq_tid_last",   32'(s_tid),   32'd0);
        step();
        check_value("final_empty", 32'(d_tvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
